// File: rtl/mux_sel_sequencer_if.sv
// -----------------------------------------------------------------------------
// mux_sel_sequencer_if
//
// Purpose:
//   Bundles the control, operand and mux-side signals of mux_sel_sequencer.
//   The master is the block that feeds the sequencer (run control and new
//   operand values). The slave is the sequencer itself, which returns the
//   select code, the registered operands and the step/wrap strobes.
//
// Signals:
//   en         master->slave  run enable; 0 freezes the sequence
//   slot_mask  master->slave  bit i enables slot i+1 (bit0 = sel 1)
//   load       master->slave  capture din_a..din_e on this edge
//   din_a..e   master->slave  new operand values, DW bits each
//   sel        slave->master  select code: 0 = none, 1..5 = slot
//   a..e       slave->master  registered operands to the mux, DW bits each
//   step       slave->master  one-cycle pulse when sel takes a slot value
//   wrap       slave->master  one-cycle pulse when the scan restarts
// -----------------------------------------------------------------------------
interface mux_sel_sequencer_if #(
  parameter int DW = 8
);
  logic          en;
  logic [4:0]    slot_mask;
  logic          load;
  logic [DW-1:0] din_a;
  logic [DW-1:0] din_b;
  logic [DW-1:0] din_c;
  logic [DW-1:0] din_d;
  logic [DW-1:0] din_e;
  logic [2:0]    sel;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] c;
  logic [DW-1:0] d;
  logic [DW-1:0] e;
  logic          step;
  logic          wrap;

  modport master (
    output en, slot_mask, load, din_a, din_b, din_c, din_d, din_e,
    input  sel, a, b, c, d, e, step, wrap
  );

  modport slave (
    input  en, slot_mask, load, din_a, din_b, din_c, din_d, din_e,
    output sel, a, b, c, d, e, step, wrap
  );
endinterface

// File: rtl/mux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// mux_sel_sequencer
//
// Purpose:
//   Upstream driver for a 5:1 byte selector. Holds five DW-bit operands in
//   registers and steps the 3-bit select code round-robin through the
//   enabled slots, dwelling DWELL cycles on each. Emits step/wrap strobes so
//   downstream logic can sample the selected byte.
//
// Parameters:
//   DWELL  cycles each slot stays selected (1..256)
//   DW     operand width in bits
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  synchronous active-low reset
//   bus    mux_sel_sequencer_if.slave (en, slot_mask, load, din_a..e in;
//          sel, a..e, step, wrap out)
//
// Build option:
//   MUX_SEQ_SHADOW_EN  when defined, load writes five shadow registers and
//                      a..e copy from the shadows only on a wrap edge, so a
//                      full scan never mixes old and new operands. When
//                      undefined, load updates a..e directly.
// -----------------------------------------------------------------------------
module mux_sel_sequencer #(
  parameter int DWELL = 4,
  parameter int DW    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_sequencer_if.slave bus
);

  // A one-cycle dwell still needs a 1-bit counter to keep the datapath legal;
  // it simply never leaves zero.
  localparam int             CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (DWELL < 1 || DWELL > 256) begin : g_bad_dwell
      $error("mux_sel_sequencer: DWELL must lie in 1..256");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  // ---------------------------------------------------------------------------
  // Slot search helpers. Slot numbers are 1..5; bit i of the mask is slot i+1.
  // ---------------------------------------------------------------------------

  // Lowest enabled slot, 0 when the mask is empty.
  function automatic logic [2:0] lowest_slot(input logic [4:0] mask);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (mask[i]) res = 3'(i + 1);
    end
    return res;
  endfunction

  // Lowest enabled slot strictly above cur; if none, wrap to the lowest
  // enabled slot overall (which may be cur itself for a single-slot mask).
  function automatic logic [2:0] next_slot(input logic [2:0] cur,
                                           input logic [4:0] mask);
    logic [2:0] res;
    res = lowest_slot(mask);
    for (int i = 4; i >= 0; i--) begin
      if (mask[i] && (3'(i + 1) > cur)) res = 3'(i + 1);
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [DW-1:0]    opr_q [5];
  logic [DW-1:0]    opr_d [5];
  logic [DW-1:0]    din   [5];
  logic [2:0]       adv_slot;

`ifdef MUX_SEQ_SHADOW_EN
  logic [DW-1:0]    shd_q [5];
  logic [DW-1:0]    shd_d [5];
`endif

  assign din[0] = bus.din_a;
  assign din[1] = bus.din_b;
  assign din[2] = bus.din_c;
  assign din[3] = bus.din_d;
  assign din[4] = bus.din_e;

  assign adv_slot = next_slot(sel_q, bus.slot_mask);

  // ---------------------------------------------------------------------------
  // Sequencing: next-state and registered-output values
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sel_d = 3'd0;
        cnt_d = '0;
        // Entry counts as both a step and a wrap: the scan starts fresh.
        if (bus.en && (bus.slot_mask != 5'd0)) begin
          state_d = ST_RUN;
          sel_d   = lowest_slot(bus.slot_mask);
          step_d  = 1'b1;
          wrap_d  = 1'b1;
        end
      end

      ST_RUN: begin
        // An empty mask ends the run on any cycle, even while frozen, and
        // emits no strobe.
        if (bus.slot_mask == 5'd0) begin
          state_d = ST_IDLE;
          sel_d   = 3'd0;
          cnt_d   = '0;
        end else if (bus.en) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            sel_d  = adv_slot;
            step_d = 1'b1;
            // Not moving upward means the scan has started over.
            wrap_d = (adv_slot <= sel_q);
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture
  // ---------------------------------------------------------------------------
`ifdef MUX_SEQ_SHADOW_EN
  // Shadows take every load; the visible operands refresh only when a wrap
  // is issued. The refresh reads shd_d so a load on the wrap edge is seen.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      shd_d[i] = bus.load ? din[i] : shd_q[i];
      opr_d[i] = wrap_d ? shd_d[i] : opr_q[i];
    end
  end
`else
  // Load lands directly, independent of state and en, so a load on an
  // advance edge reaches the mux together with the new sel.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      opr_d[i] = bus.load ? din[i] : opr_q[i];
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of order.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 3'd0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      // NOTE: the operand array is explicitly reset because its contents
      // drive the mux outputs; a register file that is only read after a
      // write could skip this, this one cannot.
      for (int i = 0; i < 5; i++) begin
        opr_q[i] <= '0;
`ifdef MUX_SEQ_SHADOW_EN
        shd_q[i] <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      for (int i = 0; i < 5; i++) begin
        opr_q[i] <= opr_d[i];
`ifdef MUX_SEQ_SHADOW_EN
        shd_q[i] <= shd_d[i];
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all straight from flops
  // ---------------------------------------------------------------------------
  assign bus.sel  = sel_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;
  assign bus.a    = opr_q[0];
  assign bus.b    = opr_q[1];
  assign bus.c    = opr_q[2];
  assign bus.d    = opr_q[3];
  assign bus.e    = opr_q[4];

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_sequencer
//
// Drives four sequencer instances (DWELL = 4, 2, 3, 1) from one shared
// stimulus stream. A behavioural model predicts each instance's outputs on
// every rising edge and queues them; a monitor on the falling edge pops the
// prediction and compares it with what the instances present.
// -----------------------------------------------------------------------------
module tb_mux_sel_sequencer;

  localparam int NI = 4;
  localparam int DW = 8;

  function automatic int dwell_of(input int k);
    case (k)
      0:       return 4;
      1:       return 2;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  typedef struct packed {
    logic [NI-1:0][2:0]         sel;
    logic [NI-1:0]              step;
    logic [NI-1:0]              wrap;
    logic [NI-1:0][4:0][DW-1:0] ops;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [4:0]    mask;
  logic          load;
  logic [DW-1:0] din_v [5];

  logic [NI-1:0][2:0]         sel_w;
  logic [NI-1:0]              step_w;
  logic [NI-1:0]              wrap_w;
  logic [NI-1:0][4:0][DW-1:0] ops_w;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT instances
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NI; g++) begin : g_dut
    mux_sel_sequencer_if #(.DW(DW)) sq_if ();

    assign sq_if.en        = en;
    assign sq_if.slot_mask = mask;
    assign sq_if.load      = load;
    assign sq_if.din_a     = din_v[0];
    assign sq_if.din_b     = din_v[1];
    assign sq_if.din_c     = din_v[2];
    assign sq_if.din_d     = din_v[3];
    assign sq_if.din_e     = din_v[4];

    assign sel_w[g]    = sq_if.sel;
    assign step_w[g]   = sq_if.step;
    assign wrap_w[g]   = sq_if.wrap;
    assign ops_w[g][0] = sq_if.a;
    assign ops_w[g][1] = sq_if.b;
    assign ops_w[g][2] = sq_if.c;
    assign ops_w[g][3] = sq_if.d;
    assign ops_w[g][4] = sq_if.e;

    mux_sel_sequencer #(.DWELL(dwell_of(g)), .DW(DW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sq_if.slave)
    );
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit            m_run [NI];
  int            m_sel [NI];
  int            m_age [NI];   // cycles already spent in the current slot
  logic [DW-1:0] m_ops [NI][5];
  logic [DW-1:0] m_sh  [NI][5];

  // Next slot in scan order: the first enabled slot numerically above cur,
  // otherwise the first enabled slot of the list (restart of the scan).
  function automatic int scan_next(input int cur, input logic [4:0] msk);
    int  slots [$];
    int  res;
    bit  found;
    for (int s = 1; s <= 5; s++) if (msk[s-1]) slots.push_back(s);
    res   = slots[0];
    found = 1'b0;
    foreach (slots[i]) begin
      if (!found && slots[i] > cur) begin
        res   = slots[i];
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always @(posedge clk) begin : model
    exp_t e;
    bit   st, wr;
    int   nxt;
    for (int k = 0; k < NI; k++) begin
      st = 1'b0;
      wr = 1'b0;
      if (!rst_n) begin
        m_run[k] = 1'b0;
        m_sel[k] = 0;
        m_age[k] = 0;
        for (int i = 0; i < 5; i++) begin
          m_ops[k][i] = '0;
          m_sh[k][i]  = '0;
        end
      end else begin
        if (!m_run[k]) begin
          if (en && mask != 5'd0) begin
            m_run[k] = 1'b1;
            m_sel[k] = scan_next(0, mask);
            m_age[k] = 0;
            st = 1'b1;
            wr = 1'b1;
          end
        end else if (mask == 5'd0) begin
          m_run[k] = 1'b0;
          m_sel[k] = 0;
          m_age[k] = 0;
        end else if (en) begin
          if (m_age[k] + 1 == dwell_of(k)) begin
            nxt      = scan_next(m_sel[k], mask);
            wr       = (nxt <= m_sel[k]);
            st       = 1'b1;
            m_sel[k] = nxt;
            m_age[k] = 0;
          end else begin
            m_age[k]++;
          end
        end
`ifdef MUX_SEQ_SHADOW_EN
        if (load) for (int i = 0; i < 5; i++) m_sh[k][i] = din_v[i];
        if (wr)   for (int i = 0; i < 5; i++) m_ops[k][i] = m_sh[k][i];
`else
        if (load) for (int i = 0; i < 5; i++) m_ops[k][i] = din_v[i];
`endif
      end
      e.sel[k]  = 3'(m_sel[k]);
      e.step[k] = st;
      e.wrap[k] = wr;
      for (int i = 0; i < 5; i++) e.ops[k][i] = m_ops[k][i];
    end
    exp_q.push_back(e);
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s dut%0d (DWELL=%0d) t=%0t: got %0h, expected %0h",
               name, k, dwell_of(k), $time, act, expv);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < NI; k++) begin
        check("sel",  k, 32'(sel_w[k]),  32'(e.sel[k]));
        check("step", k, 32'(step_w[k]), 32'(e.step[k]));
        check("wrap", k, 32'(wrap_w[k]), 32'(e.wrap[k]));
        check("a",    k, 32'(ops_w[k][0]), 32'(e.ops[k][0]));
        check("b",    k, 32'(ops_w[k][1]), 32'(e.ops[k][1]));
        check("c",    k, 32'(ops_w[k][2]), 32'(e.ops[k][2]));
        check("d",    k, 32'(ops_w[k][3]), 32'(e.ops[k][3]));
        check("e",    k, 32'(ops_w[k][4]), 32'(e.ops[k][4]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until instance 0 shows the wanted select code, within a budget.
  task automatic wait_sel0(input logic [2:0] want, input int budget);
    int t;
    t = 0;
    while (sel_w[0] !== want && t < budget) begin
      tick(1);
      t++;
    end
    check("wait_sel_timeout", 0, 32'(sel_w[0]), 32'(want));
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mask  = 5'd0;
    load  = 1'b0;
    for (int i = 0; i < 5; i++) din_v[i] = '0;
    tick(2);

    // Full mask, free running.
    rst_n = 1'b1;
    en    = 1'b1;
    mask  = 5'b11111;
    tick(26);

    // Sparse mask, changed mid-dwell.
    mask = 5'b10100;
    tick(14);

    // Single slot: step and wrap together.
    mask = 5'b00010;
    tick(12);

    // Freeze at sel 3 one cycle into the dwell, then resume.
    mask = 5'b11111;
    wait_sel0(3'd3, 40);
    tick(1);
    en = 1'b0;
    tick(5);
    en = 1'b1;
    tick(4);

    // Empty mask ends the run; then restart.
    mask = 5'b00000;
    tick(3);
    mask = 5'b11111;
    tick(3);

    // Plain load.
    load = 1'b1;
    din_v[0] = 8'h11; din_v[1] = 8'h22; din_v[2] = 8'h33;
    din_v[3] = 8'h44; din_v[4] = 8'h55;
    tick(1);
    load = 1'b0;
    tick(3);

    // Loads on every cycle for a while so some coincide with advances/wraps.
    for (int n = 0; n < 24; n++) begin
      load = 1'b1;
      for (int i = 0; i < 5; i++) din_v[i] = DW'($urandom);
      tick(1);
    end
    load = 1'b0;
    tick(6);

    // Reset mid-dwell at sel 4, then restart through IDLE entry.
    wait_sel0(3'd4, 40);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(8);

    // Randomised run.
    for (int n = 0; n < 700; n++) begin
      en   = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 15) == 0) mask = 5'($urandom);
      load = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < 5; i++) din_v[i] = DW'($urandom);
      rst_n = ($urandom_range(0, 149) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    load  = 1'b0;
    tick(4);

    // Every prediction must have been consumed by the monitor.
    @(negedge clk);
    #1;
    check("scoreboard_drain", 0, 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
